// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule types, state encoding and round constants
package aes_pkg;
  localparam int NUM_KEYS = 11;
  typedef logic [31:0] word_t;
  typedef logic [127:0] rkey_t;
  typedef enum logic [1:0] {IDLE, EXPAND, FINISHED} ks_state_t;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box byte lookup
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  always_comb begin
    out_o = 8'h00;
    case (in_i)
      8'h00: out_o = 8'h63; 8'h01: out_o = 8'h7c; 8'h02: out_o = 8'h77; 8'h03: out_o = 8'h7b;
      8'h04: out_o = 8'hf2; 8'h05: out_o = 8'h6b; 8'h06: out_o = 8'h6f; 8'h07: out_o = 8'hc5;
      8'h08: out_o = 8'h30; 8'h09: out_o = 8'h01; 8'h0a: out_o = 8'h67; 8'h0b: out_o = 8'h2b;
      8'h0c: out_o = 8'hfe; 8'h0d: out_o = 8'hd7; 8'h0e: out_o = 8'hab; 8'h0f: out_o = 8'h76;
      8'h10: out_o = 8'hca; 8'h11: out_o = 8'h82; 8'h12: out_o = 8'hc9; 8'h13: out_o = 8'h7d;
      8'h14: out_o = 8'hfa; 8'h15: out_o = 8'h59; 8'h16: out_o = 8'h47; 8'h17: out_o = 8'hf0;
      8'h18: out_o = 8'had; 8'h19: out_o = 8'hd4; 8'h1a: out_o = 8'ha2; 8'h1b: out_o = 8'haf;
      8'h1c: out_o = 8'h9c; 8'h1d: out_o = 8'ha4; 8'h1e: out_o = 8'h72; 8'h1f: out_o = 8'hc0;
      8'h20: out_o = 8'hb7; 8'h21: out_o = 8'hfd; 8'h22: out_o = 8'h93; 8'h23: out_o = 8'h26;
      8'h24: out_o = 8'h36; 8'h25: out_o = 8'h3f; 8'h26: out_o = 8'hf7; 8'h27: out_o = 8'hcc;
      8'h28: out_o = 8'h34; 8'h29: out_o = 8'ha5; 8'h2a: out_o = 8'he5; 8'h2b: out_o = 8'hf1;
      8'h2c: out_o = 8'h71; 8'h2d: out_o = 8'hd8; 8'h2e: out_o = 8'h31; 8'h2f: out_o = 8'h15;
      8'h30: out_o = 8'h04; 8'h31: out_o = 8'hc7; 8'h32: out_o = 8'h23; 8'h33: out_o = 8'hc3;
      8'h34: out_o = 8'h18; 8'h35: out_o = 8'h96; 8'h36: out_o = 8'h05; 8'h37: out_o = 8'h9a;
      8'h38: out_o = 8'h07; 8'h39: out_o = 8'h12; 8'h3a: out_o = 8'h80; 8'h3b: out_o = 8'he2;
      8'h3c: out_o = 8'heb; 8'h3d: out_o = 8'h27; 8'h3e: out_o = 8'hb2; 8'h3f: out_o = 8'h75;
      8'h40: out_o = 8'h09; 8'h41: out_o = 8'h83; 8'h42: out_o = 8'h2c; 8'h43: out_o = 8'h1a;
      8'h44: out_o = 8'h1b; 8'h45: out_o = 8'h6e; 8'h46: out_o = 8'h5a; 8'h47: out_o = 8'ha0;
      8'h48: out_o = 8'h52; 8'h49: out_o = 8'h3b; 8'h4a: out_o = 8'hd6; 8'h4b: out_o = 8'hb3;
      8'h4c: out_o = 8'h29; 8'h4d: out_o = 8'he3; 8'h4e: out_o = 8'h2f; 8'h4f: out_o = 8'h84;
      8'h50: out_o = 8'h53; 8'h51: out_o = 8'hd1; 8'h52: out_o = 8'h00; 8'h53: out_o = 8'hed;
      8'h54: out_o = 8'h20; 8'h55: out_o = 8'hfc; 8'h56: out_o = 8'hb1; 8'h57: out_o = 8'h5b;
      8'h58: out_o = 8'h6a; 8'h59: out_o = 8'hcb; 8'h5a: out_o = 8'hbe; 8'h5b: out_o = 8'h39;
      8'h5c: out_o = 8'h4a; 8'h5d: out_o = 8'h4c; 8'h5e: out_o = 8'h58; 8'h5f: out_o = 8'hcf;
      8'h60: out_o = 8'hd0; 8'h61: out_o = 8'hef; 8'h62: out_o = 8'haa; 8'h63: out_o = 8'hfb;
      8'h64: out_o = 8'h43; 8'h65: out_o = 8'h4d; 8'h66: out_o = 8'h33; 8'h67: out_o = 8'h85;
      8'h68: out_o = 8'h45; 8'h69: out_o = 8'hf9; 8'h6a: out_o = 8'h02; 8'h6b: out_o = 8'h7f;
      8'h6c: out_o = 8'h50; 8'h6d: out_o = 8'h3c; 8'h6e: out_o = 8'h9f; 8'h6f: out_o = 8'ha8;
      8'h70: out_o = 8'h51; 8'h71: out_o = 8'ha3; 8'h72: out_o = 8'h40; 8'h73: out_o = 8'h8f;
      8'h74: out_o = 8'h92; 8'h75: out_o = 8'h9d; 8'h76: out_o = 8'h38; 8'h77: out_o = 8'hf5;
      8'h78: out_o = 8'hbc; 8'h79: out_o = 8'hb6; 8'h7a: out_o = 8'hda; 8'h7b: out_o = 8'h21;
      8'h7c: out_o = 8'h10; 8'h7d: out_o = 8'hff; 8'h7e: out_o = 8'hf3; 8'h7f: out_o = 8'hd2;
      8'h80: out_o = 8'hcd; 8'h81: out_o = 8'h0c; 8'h82: out_o = 8'h13; 8'h83: out_o = 8'hec;
      8'h84: out_o = 8'h5f; 8'h85: out_o = 8'h97; 8'h86: out_o = 8'h44; 8'h87: out_o = 8'h17;
      8'h88: out_o = 8'hc4; 8'h89: out_o = 8'ha7; 8'h8a: out_o = 8'h7e; 8'h8b: out_o = 8'h3d;
      8'h8c: out_o = 8'h64; 8'h8d: out_o = 8'h5d; 8'h8e: out_o = 8'h19; 8'h8f: out_o = 8'h73;
      8'h90: out_o = 8'h60; 8'h91: out_o = 8'h81; 8'h92: out_o = 8'h4f; 8'h93: out_o = 8'hdc;
      8'h94: out_o = 8'h22; 8'h95: out_o = 8'h2a; 8'h96: out_o = 8'h90; 8'h97: out_o = 8'h88;
      8'h98: out_o = 8'h46; 8'h99: out_o = 8'hee; 8'h9a: out_o = 8'hb8; 8'h9b: out_o = 8'h14;
      8'h9c: out_o = 8'hde; 8'h9d: out_o = 8'h5e; 8'h9e: out_o = 8'h0b; 8'h9f: out_o = 8'hdb;
      8'ha0: out_o = 8'he0; 8'ha1: out_o = 8'h32; 8'ha2: out_o = 8'h3a; 8'ha3: out_o = 8'h0a;
      8'ha4: out_o = 8'h49; 8'ha5: out_o = 8'h06; 8'ha6: out_o = 8'h24; 8'ha7: out_o = 8'h5c;
      8'ha8: out_o = 8'hc2; 8'ha9: out_o = 8'hd3; 8'haa: out_o = 8'hac; 8'hab: out_o = 8'h62;
      8'hac: out_o = 8'h91; 8'had: out_o = 8'h95; 8'hae: out_o = 8'he4; 8'haf: out_o = 8'h79;
      8'hb0: out_o = 8'he7; 8'hb1: out_o = 8'hc8; 8'hb2: out_o = 8'h37; 8'hb3: out_o = 8'h6d;
      8'hb4: out_o = 8'h8d; 8'hb5: out_o = 8'hd5; 8'hb6: out_o = 8'h4e; 8'hb7: out_o = 8'ha9;
      8'hb8: out_o = 8'h6c; 8'hb9: out_o = 8'h56; 8'hba: out_o = 8'hf4; 8'hbb: out_o = 8'hea;
      8'hbc: out_o = 8'h65; 8'hbd: out_o = 8'h7a; 8'hbe: out_o = 8'hae; 8'hbf: out_o = 8'h08;
      8'hc0: out_o = 8'hba; 8'hc1: out_o = 8'h78; 8'hc2: out_o = 8'h25; 8'hc3: out_o = 8'h2e;
      8'hc4: out_o = 8'h1c; 8'hc5: out_o = 8'ha6; 8'hc6: out_o = 8'hb4; 8'hc7: out_o = 8'hc6;
      8'hc8: out_o = 8'he8; 8'hc9: out_o = 8'hdd; 8'hca: out_o = 8'h74; 8'hcb: out_o = 8'h1f;
      8'hcc: out_o = 8'h4b; 8'hcd: out_o = 8'hbd; 8'hce: out_o = 8'h8b; 8'hcf: out_o = 8'h8a;
      8'hd0: out_o = 8'h70; 8'hd1: out_o = 8'h3e; 8'hd2: out_o = 8'hb5; 8'hd3: out_o = 8'h66;
      8'hd4: out_o = 8'h48; 8'hd5: out_o = 8'h03; 8'hd6: out_o = 8'hf6; 8'hd7: out_o = 8'h0e;
      8'hd8: out_o = 8'h61; 8'hd9: out_o = 8'h35; 8'hda: out_o = 8'h57; 8'hdb: out_o = 8'hb9;
      8'hdc: out_o = 8'h86; 8'hdd: out_o = 8'hc1; 8'hde: out_o = 8'h1d; 8'hdf: out_o = 8'h9e;
      8'he0: out_o = 8'he1; 8'he1: out_o = 8'hf8; 8'he2: out_o = 8'h98; 8'he3: out_o = 8'h11;
      8'he4: out_o = 8'h69; 8'he5: out_o = 8'hd9; 8'he6: out_o = 8'h8e; 8'he7: out_o = 8'h94;
      8'he8: out_o = 8'h9b; 8'he9: out_o = 8'h1e; 8'hea: out_o = 8'h87; 8'heb: out_o = 8'he9;
      8'hec: out_o = 8'hce; 8'hed: out_o = 8'h55; 8'hee: out_o = 8'h28; 8'hef: out_o = 8'hdf;
      8'hf0: out_o = 8'h8c; 8'hf1: out_o = 8'ha1; 8'hf2: out_o = 8'h89; 8'hf3: out_o = 8'h0d;
      8'hf4: out_o = 8'hbf; 8'hf5: out_o = 8'he6; 8'hf6: out_o = 8'h42; 8'hf7: out_o = 8'h68;
      8'hf8: out_o = 8'h41; 8'hf9: out_o = 8'h99; 8'hfa: out_o = 8'h2d; 8'hfb: out_o = 8'h0f;
      8'hfc: out_o = 8'hb0; 8'hfd: out_o = 8'h54; 8'hfe: out_o = 8'hbb; 8'hff: out_o = 8'h16;
      default: out_o = 8'h00;
    endcase
  end
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion into an indexed round-key buffer; AES_KS_REVERSE_IDX_EN reverses the read index
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [3:0]   ROUND_IDX,
  output logic [127:0] ROUND_KEY,
  output logic         BUSY,
  output logic         DONE
);
  ks_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, wr_idx, rd_idx;
  rkey_t w_q, wr_data;
  rkey_t key_q [NUM_KEYS];
  word_t rot, sub, temp, n0, n1, n2, n3;
  logic last, wr_en;
  assign rot = {w_q[23:0], w_q[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.in_i(rot[8*g +: 8]), .out_o(sub[8*g +: 8]));
  end
  assign temp = sub ^ {RCON[cnt_q], 24'h0};
  assign n0 = w_q[127:96] ^ temp;
  assign n1 = w_q[95:64] ^ n0;
  assign n2 = w_q[63:32] ^ n1;
  assign n3 = w_q[31:0] ^ n2;
  assign last = cnt_q == 4'(NUM_ROUNDS);
  always_ff @(posedge CLK)
    if (RESET) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = START ? EXPAND : IDLE;
      EXPAND:   state_d = !START ? IDLE : last ? FINISHED : EXPAND;
      FINISHED: state_d = START ? FINISHED : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // An abort (START low) in EXPAND suppresses the write at that edge
  always_comb begin
    BUSY = state_q == EXPAND;
    DONE = state_q == FINISHED;
    wr_en = START && (state_q == IDLE || state_q == EXPAND);
    wr_idx = state_q == IDLE ? 4'd0 : cnt_q;
    wr_data = state_q == IDLE ? KEY : {n0, n1, n2, n3};
    cnt_d = state_q == IDLE ? 4'd1 : last ? cnt_q : cnt_q + 4'd1;
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      w_q <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      w_q <= wr_data;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge CLK)
    for (int i = 0; i < NUM_KEYS; i++)
      if (RESET) key_q[i] <= '0;
      else if (wr_en && wr_idx == i[3:0]) key_q[i] <= wr_data;
`ifdef AES_KS_REVERSE_IDX_EN
  assign rd_idx = 4'(NUM_ROUNDS) - ROUND_IDX;
`else
  assign rd_idx = ROUND_IDX;
`endif
  assign ROUND_KEY = ROUND_IDX <= 4'(NUM_ROUNDS) ? key_q[rd_idx] : '0;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: directed and randomized checks against a GF(2^8)-derived key expansion model
module tb_aes_key_schedule;
  import aes_pkg::*;
  logic CLK = 1'b0;
  logic RESET, START;
  rkey_t KEY, ROUND_KEY;
  logic [3:0] ROUND_IDX;
  logic BUSY, DONE;
  int tests = 0, fails = 0;
  logic [7:0] sb [256];
  rkey_t exp_k [11];
  rkey_t fips_k [11];
  localparam rkey_t FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  always #5 CLK = ~CLK;

  aes_key_schedule dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KEY(KEY), .ROUND_IDX(ROUND_IDX),
    .ROUND_KEY(ROUND_KEY), .BUSY(BUSY), .DONE(DONE)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic word_t subword(word_t x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Index that reads buffer entry e (the reversed mapping is its own inverse)
  function automatic int ent(int e);
`ifdef AES_KS_REVERSE_IDX_EN
    return 10 - e;
`else
    return e;
`endif
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = b;
    end
  endtask

  task automatic expand(rkey_t key);
    word_t w [44];
    word_t t;
    logic [7:0] rc;
    rc = 8'h01;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(string tag, rkey_t obs, rkey_t expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic read_chk(int idx, rkey_t expv, string tag);
    ROUND_IDX = 4'(idx);
    #1;
    chk($sformatf("%s[%0d]", tag, idx), ROUND_KEY, expv);
  endtask

  task automatic check_reads(string tag, bit zero);
    for (int i = 0; i < 16; i++)
      read_chk(i, (zero || i > 10) ? '0 : exp_k[ent(i)], tag);
  endtask

  task automatic run_full(rkey_t key, string tag);
    int n;
    expand(key);
    @(negedge CLK); KEY = key; START = 1'b1;
    @(negedge CLK); KEY = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!DONE && n < 20) begin @(negedge CLK); n++; end
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_cycles"}, n, 10);
    check_reads(tag, 0);
    START = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    rkey_t k2;
    build_sbox();
    RESET = 1'b1; START = 1'b0; KEY = '0; ROUND_IDX = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    check_reads("rst_zero", 1);
    // FIPS-197 key, KEY scrambled to all-ones once latched
    expand(FIPS);
    fips_k = exp_k;
    @(negedge CLK); KEY = FIPS; START = 1'b1;
    @(negedge CLK); KEY = '1;
    chk("s1_busy0", BUSY, 1);
    chk("s1_done0", DONE, 0);
    read_chk(ent(0), FIPS, "s1_key");
    for (int j = 1; j <= 10; j++) begin
      @(negedge CLK);
      chk($sformatf("s1_busy%0d", j), BUSY, (j < 10) ? 1 : 0);
      chk($sformatf("s1_done%0d", j), DONE, (j == 10) ? 1 : 0);
      read_chk(ent(j), exp_k[j], "s1_fresh");
    end
    read_chk(ent(1), 128'ha0fafe17_88542cb1_23a33939_2a6c7605, "s1_fips1");
    read_chk(ent(10), 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "s1_fips10");
    check_reads("s1_all", 0);
    // Hold START after DONE, then release
    repeat (3) begin @(negedge CLK); chk("s2_hold_done", DONE, 1); chk("s2_hold_busy", BUSY, 0); end
    START = 1'b0;
    @(negedge CLK);
    chk("s2_done_clr", DONE, 0);
    chk("s2_busy", BUSY, 0);
    check_reads("s2_keep", 0);
    // Abort in the 4th EXPAND cycle
    k2 = {$urandom, $urandom, $urandom, $urandom};
    expand(k2);
    @(negedge CLK); KEY = k2; START = 1'b1;
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("s3_busy", BUSY, 0);
    chk("s3_done", DONE, 0);
    for (int j = 0; j < 4; j++) read_chk(ent(j), exp_k[j], "s3_part");
    read_chk(ent(4), fips_k[4], "s3_stale");
    repeat (3) begin @(negedge CLK); chk("s3_no_done", DONE, 0); end
    run_full('0, "s3_zero");
    read_chk(ent(10), 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e, "s3_zero10");
    for (int r = 0; r < 3; r++) run_full({$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd%0d", r));
    // Reset mid-expansion
    @(negedge CLK); KEY = {$urandom, $urandom, $urandom, $urandom}; START = 1'b1;
    repeat (5) @(negedge CLK);
    chk("s4_busy_pre", BUSY, 1);
    RESET = 1'b1; START = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    chk("s4_busy", BUSY, 0);
    chk("s4_done", DONE, 0);
    check_reads("s4_zero", 1);
    run_full(FIPS, "s4_again");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
